coef_collector: RTL and testbench
=================================

COEF_COLLECTOR -- requirements
Module: coef_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one attention coefficient.
REQ-002 Parameter MAX_NODES, default 168, maximum coefficients per subgraph.
REQ-003 Parameter NUM_NODE_WIDTH, default $clog2(MAX_NODES), width of the node-count field.
REQ-004 Parameter SOFTMAX_WIDTH, default MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH, width of one packed output word.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 coef_ff_dout  in  DATA_WIDTH  coefficient FIFO read data, valid one cycle after coef_ff_rd_vld.
REQ-008 coef_ff_empty  in  1  coefficient FIFO empty.
REQ-009 coef_ff_rd_vld  out  1  coefficient FIFO pop.
REQ-010 num_node_ff_dout  in  NUM_NODE_WIDTH  node-count FIFO read data, valid one cycle after pop.
REQ-011 num_node_ff_empty  in  1  node-count FIFO empty.
REQ-012 num_node_ff_rd_vld  out  1  node-count FIFO pop.
REQ-013 sm_ff_din  out  SOFTMAX_WIDTH  packed subgraph word to softmax FIFO.
REQ-014 sm_ff_full  in  1  softmax FIFO full.
REQ-015 sm_ff_wr_vld  out  1  softmax FIFO push.
REQ-016 busy_o  out  1  high in any state other than IDLE.

Function
REQ-017 FSM states IDLE, LOAD, COLLECT, WRITE; IDLE->LOAD when !num_node_ff_empty, asserting num_node_ff_rd_vld for exactly that one cycle.
REQ-018 LOAD latches n = num_node_ff_dout, saturating values >MAX_NODES to MAX_NODES; n==0 -> WRITE, else -> COLLECT.
REQ-019 COLLECT asserts coef_ff_rd_vld whenever !coef_ff_empty and issued reads < n; no read beyond n is issued.
REQ-020 Data captured one cycle after each pop; k-th captured coefficient (k from 0) placed at sm_ff_din[SOFTMAX_WIDTH-1-k*DATA_WIDTH -: DATA_WIDTH].
REQ-021 Unfilled slots k>=n are 0; sm_ff_din[NUM_NODE_WIDTH-1:0] = n (saturated).
REQ-022 COLLECT -> WRITE in the cycle after the n-th capture.
REQ-023 WRITE: sm_ff_wr_vld = !sm_ff_full; sm_ff_din held stable while full; on push -> IDLE and vector cleared to 0.
REQ-024 Latency with FIFOs never empty/full: sm_ff_wr_vld high exactly n+3 cycles after the num_node_ff_rd_vld cycle (3 for n==0).
REQ-025 coef_ff_empty mid-subgraph: reads stall, state stays COLLECT, captured count and vector preserved; resume on next non-empty.
REQ-026 IDLE->LOAD may occur in the cycle following a WRITE push (no dead cycle required beyond IDLE).
REQ-027 num_node_ff_rd_vld and coef_ff_rd_vld never high in the same cycle.

Reset
REQ-028 On rst: state IDLE, counts 0, vector 0, coef_ff_rd_vld=0, num_node_ff_rd_vld=0, sm_ff_wr_vld=0, busy_o=0, sm_ff_din=0.
REQ-029 rst mid-subgraph discards partial data; no push occurs; already-popped FIFO entries are not replayed.

Configuration
REQ-030 Macro COEF_MAX_TRACK_EN defined: extra output coef_max_o (DATA_WIDTH, unsigned) = max of the n captured coefficients, 0 if n==0, valid and stable whenever sm_ff_wr_vld; reset to 0, cleared on push.
REQ-031 COEF_MAX_TRACK_EN undefined: coef_max_o port and comparator absent; all other behaviour identical.

Verification
REQ-032 n=3, coefs 0x05,0x7F,0x10 back-to-back -> one push at cycle pop+6, top bytes 05 7F 10, rest 0, LSB field 3, coef_max_o=0x7F.
REQ-033 n=0 -> push at pop+3 with all-zero vector, field 0, no coef_ff_rd_vld.
REQ-034 n=4, coef_ff_empty high 5 cycles after 2nd read -> exactly 4 reads, correct order, push at pop+12.
REQ-035 n=2, sm_ff_full high 4 cycles in WRITE -> sm_ff_wr_vld low 4 cycles, sm_ff_din unchanged, single push after release.
REQ-036 n=200 and n=168 (168 coefs supplied) -> both saturate to 168, all slots filled, field 168, exactly 168 reads each.
REQ-037 rst asserted after 2 of n=5 captures, then n=1 coef 0x22 -> only one push: 0x22 in slot 0, field 1.

Source files
------------

// File: rtl/coef_collector.sv
// coef_collector: gathers one subgraph's attention coefficients from the
// coefficient FIFO and packs them into a single word for the softmax FIFO.
// The node count comes first from the node-count FIFO. Counts above MAX_NODES
// are clamped to MAX_NODES. Coefficient k goes into the k-th byte slot, counted
// from the MSB. The clamped count sits in the LSB field.
// Optional feature: define COEF_MAX_TRACK_EN to add coef_max_o. This port
// carries the unsigned maximum of the captured coefficients.
module coef_collector #(
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_NODES      = 168,
    parameter int NUM_NODE_WIDTH = $clog2(MAX_NODES),
    parameter int SOFTMAX_WIDTH  = MAX_NODES*DATA_WIDTH+NUM_NODE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     coef_ff_dout,
    input  logic                      coef_ff_empty,
    output logic                      coef_ff_rd_vld,
    input  logic [NUM_NODE_WIDTH-1:0] num_node_ff_dout,
    input  logic                      num_node_ff_empty,
    output logic                      num_node_ff_rd_vld,
    output logic [SOFTMAX_WIDTH-1:0]  sm_ff_din,
    input  logic                      sm_ff_full,
    output logic                      sm_ff_wr_vld,
    output logic                      busy_o
`ifdef COEF_MAX_TRACK_EN
    ,
    output logic [DATA_WIDTH-1:0]     coef_max_o
`endif
);

    // Counters must be able to hold MAX_NODES itself.
    localparam int CNT_W = $clog2(MAX_NODES+1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COLLECT = 2'd2,
        S_WRITE   = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         n_q, n_d;
    logic [CNT_W-1:0]         issued_q, issued_d;
    logic [CNT_W-1:0]         capt_q, capt_d;
    logic                     cap_pend_q, cap_pend_d;
    logic                     wr_arm_q, wr_arm_d;
    logic                     busy_q, busy_d;
    logic [SOFTMAX_WIDTH-1:0] vec_q, vec_d;
`ifdef COEF_MAX_TRACK_EN
    logic [DATA_WIDTH-1:0]    max_q, max_d;
`endif

    logic [CNT_W-1:0]          n_sat_s;
    logic [NUM_NODE_WIDTH:0]   n_raw_s;
    logic                      num_rd_s;
    logic                      coef_rd_s;
    logic                      push_s;
    int                        slot_hi_s;

    // Clamp the incoming node count to MAX_NODES.
    always_comb begin
        n_raw_s = {1'b0, num_node_ff_dout};
        if (n_raw_s > (NUM_NODE_WIDTH+1)'(MAX_NODES)) begin
            n_sat_s = CNT_W'(MAX_NODES);
        end else begin
            n_sat_s = CNT_W'(num_node_ff_dout);
        end
    end

    // FIFO handshakes. In LOAD, the first coefficient read already uses the
    // count arriving from the node-count FIFO.
    always_comb begin
        num_rd_s  = 1'b0;
        coef_rd_s = 1'b0;
        push_s    = 1'b0;
        if (rst) begin
            num_rd_s  = 1'b0;
            coef_rd_s = 1'b0;
            push_s    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE:    num_rd_s  = !num_node_ff_empty;
                S_LOAD:    coef_rd_s = (n_sat_s != {CNT_W{1'b0}}) && !coef_ff_empty;
                S_COLLECT: coef_rd_s = (issued_q < n_q) && !coef_ff_empty;
                S_WRITE:   push_s    = wr_arm_q && !sm_ff_full;
                default:   push_s    = 1'b0;
            endcase
        end
    end

    // Next-state logic: capture returning data, sequence the subgraph, clear on push.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        issued_d   = issued_q;
        capt_d     = capt_q;
        cap_pend_d = coef_rd_s;
        wr_arm_d   = wr_arm_q;
        vec_d      = vec_q;
`ifdef COEF_MAX_TRACK_EN
        max_d      = max_q;
`endif
        slot_hi_s  = SOFTMAX_WIDTH - 1 - int'(capt_q) * DATA_WIDTH;

        if (cap_pend_q) begin
            vec_d[slot_hi_s -: DATA_WIDTH] = coef_ff_dout;
            capt_d = capt_q + CNT_W'(1);
`ifdef COEF_MAX_TRACK_EN
            if (coef_ff_dout > max_q) begin
                max_d = coef_ff_dout;
            end else begin
                max_d = max_q;
            end
`endif
        end else begin
            capt_d = capt_q;
        end

        case (state_q)
            S_IDLE: begin
                if (num_rd_s) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                n_d      = n_sat_s;
                vec_d[NUM_NODE_WIDTH-1:0] = n_sat_s[NUM_NODE_WIDTH-1:0];
                issued_d = coef_rd_s ? CNT_W'(1) : {CNT_W{1'b0}};
                wr_arm_d = 1'b0;
                if (n_sat_s == {CNT_W{1'b0}}) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (coef_rd_s) begin
                    issued_d = issued_q + CNT_W'(1);
                end else begin
                    issued_d = issued_q;
                end
                if (cap_pend_q && ((capt_q + CNT_W'(1)) == n_q)) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_WRITE: begin
                wr_arm_d = 1'b1;
                if (push_s) begin
                    state_d  = S_IDLE;
                    n_d      = {CNT_W{1'b0}};
                    issued_d = {CNT_W{1'b0}};
                    capt_d   = {CNT_W{1'b0}};
                    wr_arm_d = 1'b0;
                    vec_d    = {SOFTMAX_WIDTH{1'b0}};
`ifdef COEF_MAX_TRACK_EN
                    max_d    = {DATA_WIDTH{1'b0}};
`endif
                end else begin
                    state_d = S_WRITE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers; reset discards any partial subgraph.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            n_q        <= {CNT_W{1'b0}};
            issued_q   <= {CNT_W{1'b0}};
            capt_q     <= {CNT_W{1'b0}};
            cap_pend_q <= 1'b0;
            wr_arm_q   <= 1'b0;
            busy_q     <= 1'b0;
            vec_q      <= {SOFTMAX_WIDTH{1'b0}};
`ifdef COEF_MAX_TRACK_EN
            max_q      <= {DATA_WIDTH{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            issued_q   <= issued_d;
            capt_q     <= capt_d;
            cap_pend_q <= cap_pend_d;
            wr_arm_q   <= wr_arm_d;
            busy_q     <= busy_d;
            vec_q      <= vec_d;
`ifdef COEF_MAX_TRACK_EN
            max_q      <= max_d;
`endif
        end
    end

    assign num_node_ff_rd_vld = num_rd_s;
    assign coef_ff_rd_vld     = coef_rd_s;
    assign sm_ff_wr_vld       = push_s;
    assign sm_ff_din          = vec_q;
    assign busy_o             = busy_q;
`ifdef COEF_MAX_TRACK_EN
    assign coef_max_o         = max_q;
`endif

endmodule

// File: tb/tb_coef_collector.sv
// Scoreboard bench for coef_collector (build with or without COEF_MAX_TRACK_EN).
module tb_coef_collector;
    localparam int DW = 8;
    localparam int MN = 168;
    localparam int NW = $clog2(MN);
    localparam int SW = MN*DW+NW;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] coef_ff_dout;
    logic          coef_ff_empty;
    logic          coef_ff_rd_vld;
    logic [NW-1:0] num_node_ff_dout;
    logic          num_node_ff_empty;
    logic          num_node_ff_rd_vld;
    logic [SW-1:0] sm_ff_din;
    logic          sm_ff_full;
    logic          sm_ff_wr_vld;
    logic          busy_o;
`ifdef COEF_MAX_TRACK_EN
    logic [DW-1:0] coef_max_o;
`endif

    always #5 clk = ~clk;

    coef_collector dut (
        .clk(clk), .rst(rst),
        .coef_ff_dout(coef_ff_dout), .coef_ff_empty(coef_ff_empty),
        .coef_ff_rd_vld(coef_ff_rd_vld),
        .num_node_ff_dout(num_node_ff_dout), .num_node_ff_empty(num_node_ff_empty),
        .num_node_ff_rd_vld(num_node_ff_rd_vld),
        .sm_ff_din(sm_ff_din), .sm_ff_full(sm_ff_full), .sm_ff_wr_vld(sm_ff_wr_vld),
        .busy_o(busy_o)
`ifdef COEF_MAX_TRACK_EN
        , .coef_max_o(coef_max_o)
`endif
    );

    typedef struct {
        logic [SW-1:0] din;
        int            lat;
        int            reads;
        logic [DW-1:0] mx;
    } exp_t;

    exp_t          sb[$];
    logic [NW-1:0] nq[$];
    logic [DW-1:0] cq[$];
    logic [DW-1:0] stage[$];
    int            pcq[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int mon_reads   = 0;
    int model_reads = 0;
    int stall_cnt   = 0;
    int since       = 100;
    bit stall_after2 = 1'b0;
    bit full_mode    = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Queue expected packed word, latency and read count; hand stimulus to FIFO models.
    task automatic issue(input int n_raw, input int extra_lat);
        exp_t e;
        int   nsat;
        nsat  = (n_raw > MN) ? MN : n_raw;
        e.din = '0;
        e.mx  = '0;
        for (int k = 0; k < nsat; k++) begin
            e.din[SW-1-k*DW -: DW] = stage[k];
            if (stage[k] > e.mx) e.mx = stage[k];
        end
        e.din[NW-1:0] = NW'(nsat);
        e.lat   = nsat + 3 + extra_lat;
        e.reads = nsat;
        sb.push_back(e);
        nq.push_back(NW'(n_raw));
        foreach (stage[i]) cq.push_back(stage[i]);
        stage.delete();
    endtask

    task automatic wait_done(input int bound);
        int t = 0;
        while ((sb.size() != 0 || nq.size() != 0) && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (t >= bound) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d entries outstanding after %0d cycles", sb.size(), bound);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // FIFO models: pops seen mid-cycle take effect just after the next rising edge.
    initial begin
        bit np, cp;
        coef_ff_dout = '0; num_node_ff_dout = '0;
        coef_ff_empty = 1'b1; num_node_ff_empty = 1'b1; sm_ff_full = 1'b0;
        forever begin
            @(negedge clk);
            np = num_node_ff_rd_vld;
            cp = coef_ff_rd_vld;
            @(posedge clk);
            #1;
            if (stall_cnt > 0) stall_cnt--;
            if (np) begin
                num_node_ff_dout = nq.pop_front();
                since = 1;
            end else begin
                since++;
            end
            if (cp) begin
                coef_ff_dout = cq.pop_front();
                model_reads++;
                if (stall_after2 && model_reads == 2) begin
                    stall_cnt    = 5;
                    stall_after2 = 1'b0;
                end
            end
            sm_ff_full        = full_mode && since >= 5 && since <= 8;
            coef_ff_empty     = (cq.size() == 0) || (stall_cnt > 0);
            num_node_ff_empty = (nq.size() == 0);
        end
    end

    // Monitor: compare every push against the scoreboard head.
    initial begin
        exp_t          e;
        logic [SW-1:0] prev_din = '0;
        logic          prev_full = 1'b0;
        int            bad;
        forever begin
            @(negedge clk);
            cyc++;
            if (num_node_ff_rd_vld && coef_ff_rd_vld) begin
                n_tests++; n_fail++;
                $display("FAIL pop_exclusive: both pops high at cycle %0d", cyc);
            end
            if (num_node_ff_rd_vld) pcq.push_back(cyc);
            if (coef_ff_rd_vld) mon_reads++;
            if (sm_ff_full) check("wr_while_full", longint'(sm_ff_wr_vld), 0);
            if (sm_ff_full && prev_full) begin
                n_tests++;
                if (sm_ff_din != prev_din) begin
                    n_fail++;
                    $display("FAIL din_stable_full: word changed while full at cycle %0d, expected unchanged", cyc);
                end
            end
            if (sm_ff_wr_vld) begin
                if (sb.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL extra_push: push at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    n_tests++;
                    if (sm_ff_din != e.din) begin
                        n_fail++;
                        bad = -1;
                        for (int k = SW/DW - 1; k >= 0; k--) begin
                            if (sm_ff_din[k*DW +: DW] != e.din[k*DW +: DW]) bad = k;
                        end
                        $display("FAIL packed_word: byte %0d (from LSB) got %0h expected %0h",
                                 bad, sm_ff_din[bad*DW +: DW], e.din[bad*DW +: DW]);
                    end
                    if (pcq.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL latency: push without count pop, expected %0d", e.lat);
                    end else begin
                        check("latency", longint'(cyc - pcq.pop_front()), longint'(e.lat));
                    end
                    check("read_count", longint'(mon_reads), longint'(e.reads));
`ifdef COEF_MAX_TRACK_EN
                    check("coef_max", longint'(coef_max_o), longint'(e.mx));
`endif
                    mon_reads = 0;
                end
            end
            prev_full = sm_ff_full;
            prev_din  = sm_ff_din;
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy_o), 0);
        check("rst_wr_vld", longint'(sm_ff_wr_vld), 0);
        check("rst_num_rd", longint'(num_node_ff_rd_vld), 0);
        check("rst_coef_rd", longint'(coef_ff_rd_vld), 0);
        check("rst_din_zero", longint'(sm_ff_din != '0), 0);
        rst = 1'b0;
        @(negedge clk);

        // n=3 followed back-to-back by n=0
        stage = '{8'h05, 8'h7F, 8'h10};
        issue(3, 0);
        issue(0, 0);
        wait_done(200);

        // n=4 with the coefficient FIFO running dry after the second read
        model_reads  = 0;
        stall_after2 = 1'b1;
        stage = '{8'h11, 8'h22, 8'h33, 8'h44};
        issue(4, 5);
        wait_done(200);

        // n=2 with softmax FIFO full for four cycles in WRITE
        full_mode = 1'b1;
        stage = '{8'hAA, 8'hBB};
        issue(2, 4);
        wait_done(200);
        full_mode = 1'b0;

        // n=200 saturates; n=168 exact
        for (int k = 0; k < MN; k++) stage.push_back(DW'(k*7+3));
        issue(200, 0);
        wait_done(1000);
        for (int k = 0; k < MN; k++) stage.push_back(DW'(255-k));
        issue(168, 0);
        wait_done(1000);

        // reset in the middle of an n=5 subgraph after two captures
        nq.push_back(NW'(5));
        cq.push_back(8'h01);
        cq.push_back(8'h02);
        repeat (10) @(negedge clk);
        check("busy_mid_subgraph", longint'(busy_o), 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pcq.delete();
        mon_reads = 0;
        @(negedge clk);
        check("busy_after_rst", longint'(busy_o), 0);
        check("din_after_rst", longint'(sm_ff_din != '0), 0);
        stage = '{8'h22};
        issue(1, 0);
        wait_done(200);

        repeat (10) @(negedge clk);
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
